uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter, next generation of the lab serial TX path.
//  - Accepts parallel words on a valid/ready handshake into an internal FIFO.
//  - Serialises each word LSB-first with a start bit, optional parity and 1 or 2 stop bits.
//  - Baud timing comes from an internal divider: single clock domain, no external bit clock, no CDC.
// PARAMETERS
//  DATA_W        8   data bits per frame, legal 5..9
//  CLKS_PER_BIT  16  pclk_i cycles per serial bit, >= 2
//  STOP_BITS     1   stop bits per frame, 1 or 2
//  FIFO_DEPTH    4   FIFO entries, power of 2, >= 2
//  PARITY_ODD    0   0 = even parity, 1 = odd; used only with UART_TX_PARITY_EN
// PORTS
//  pclk_i           in   1                     clock, all logic on rising edge
//  prst_n_i         in   1                     reset, asynchronous assert, active-low
//  tx_pdata_i       in   DATA_W                parallel word to send
//  tx_pdata_valid_i in   1                     word valid
//  tx_pready_o      out  1                     FIFO can accept (= !full)
//  tx_sdata_o       out  1                     serial line, idle high, registered
//  tx_busy_o        out  1                     FSM not in IDLE
//  tx_done_o        out  1                     1-cycle pulse at end of each frame
//  tx_fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, while prst_n_i=0)
//   - tx_sdata_o=1, tx_busy_o=0, tx_done_o=0, level=0, tx_pready_o=1.
//   - FIFO pointers cleared, FSM=IDLE, baud and bit counters=0.
//  Handshake
//   - Push on rising edge when tx_pdata_valid_i & tx_pready_o.
//   - tx_pready_o derives only from registered level; no combinational path from valid.
//   - Full FIFO with a same-cycle pop: push still refused (ready=0).
//   - Simultaneous push and pop: level unchanged.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START
//   - IDLE: line=1. FIFO non-empty -> pop head into shift reg; next edge START, line=0.
//   - First start bit drives tx_sdata_o one cycle after the accepting edge (empty FIFO, IDLE).
//   - Every bit is held exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1 restarts per bit.
//   - DATA: DATA_W bits, LSB first; bit index counts 0..DATA_W-1.
//   - PARITY: only with macro. Bit = ^data ^ PARITY_ODD.
//   - STOP: line=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Last stop cycle: tx_done_o=1. FIFO non-empty -> pop and go straight to START (no idle gap); else IDLE.
//   - Frame length = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, P = 1 with parity, else 0.
//  Boundaries
//   - Word being shifted is no longer in the FIFO: capacity = FIFO_DEPTH queued + 1 in flight.
//   - FIFO pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
//   - Push while busy is legal and never disturbs the frame in flight.
//   - Reset mid-frame aborts immediately: line=1, FIFO flushed, no done pulse.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state present; one parity bit per frame, even/odd per PARITY_ODD.
//  UART_TX_PARITY_EN undefined:
//   - No PARITY state or parity logic; DATA goes directly to STOP; PARITY_ODD ignored.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
//  1. Reset, hold 5 cycles -> tx_sdata_o=1, tx_pready_o=1, level=0, busy=0, done=0.
//  2. Push 0xA5 once, no parity -> line 0 for 4 cycles from the edge after accept;
//     then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
//     done pulse in the 40th frame cycle; busy=0 after.
//  3. Push 0x01..0x06 with valid held every cycle -> 0x01..0x05 accepted;
//     level=4 and ready=0 after the 5th push; 0x06 accepted on the cycle after the first done;
//     6 contiguous frames, no idle gap.
//  4. UART_TX_PARITY_EN, push 0x07 -> parity bit 1 with PARITY_ODD=0, 0 with PARITY_ODD=1;
//     frame 44 cycles.
//  5. Assert prst_n_i during data bit 3 with 2 words queued -> line=1 same cycle, level=0, ready=1;
//     after release, push 0x3C -> clean full frame for 0x3C only.
//  6. STOP_BITS=2, push 0xFF, 0x00 back-to-back -> line high exactly 8 cycles between frames;
//     each frame 44 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, single clock domain.
// Words enter through a valid/ready handshake and are sent LSB first with a
// start bit, an optional parity bit and STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (even, or odd with PARITY_ODD=1).
//
// state    | meaning
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit, line low
// S_DATA   | data bits, LSB first, bit_q = index
// S_PARITY | parity bit (UART_TX_PARITY_EN only)
// S_STOP   | stop bit(s), line high; last cycle pulses tx_done_o
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          pclk_i,
  input  logic                          prst_n_i,
  input  logic [DATA_W-1:0]             tx_pdata_i,
  input  logic                          tx_pdata_valid_i,
  output logic                          tx_pready_o,
  output logic                          tx_sdata_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push, pop, fifo_empty, frame_end, baud_end;

  state_t            state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              sdata_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`else
  // PARITY_ODD only matters with the parity bit; referenced here so it stays in the interface.
  if (PARITY_ODD > 1) begin : g_parity_odd_unused
  end
`endif

  // Ready depends only on the registered level, so a full FIFO refuses a push
  // even when the FSM pops in the same cycle.
  assign tx_pready_o     = (level_q != LVL_FULL);
  assign fifo_empty      = (level_q == '0);
  assign push            = tx_pdata_valid_i & tx_pready_o;
  assign baud_end        = (baud_q == BAUD_LAST);
  assign frame_end       = (state_q == S_STOP) && baud_end && (bit_q == STOP_LAST);
  // Head is taken either from idle or on the last stop cycle (no idle gap between frames).
  assign pop             = !fifo_empty && ((state_q == S_IDLE) || frame_end);

  assign tx_sdata_o      = sdata_q;
  assign tx_done_o       = done_q;
  assign tx_busy_o       = (state_q != S_IDLE);
  assign tx_fifo_level_o = level_q;

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO storage, written on accepted pushes only.
  always_ff @(posedge pclk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_pdata_i;
    end
  end

  // FIFO pointers wrap naturally (power-of-two depth); level tells full from empty.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Frame sequencer with registered line and done outputs.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sdata_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // Set one cycle early so the pulse lands on the last stop cycle.
      done_q <= (state_q == S_STOP) && (baud_q == BAUD_PRE) && (bit_q == STOP_LAST);
      if (pop) begin
        state_q <= S_START;
        shift_q <= mem_q[rd_ptr_q];
        baud_q  <= '0;
        bit_q   <= '0;
        sdata_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^mem_q[rd_ptr_q]) ^ 1'(PARITY_ODD);
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            sdata_q <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
          end
          S_START: begin
            if (baud_end) begin
              state_q <= S_DATA;
              baud_q  <= '0;
              sdata_q <= shift_q[0];
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (baud_end) begin
              baud_q <= '0;
              if (bit_q == DATA_LAST) begin
                bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                state_q <= S_PARITY;
                sdata_q <= par_q;
`else
                state_q <= S_STOP;
                sdata_q <= 1'b1;
`endif
              end else begin
                bit_q   <= bit_q + BIT_W'(1);
                shift_q <= shift_q >> 1;
                sdata_q <= shift_q[1];
              end
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (baud_end) begin
              state_q <= S_STOP;
              baud_q  <= '0;
              sdata_q <= 1'b1;
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end
`endif
          S_STOP: begin
            if (baud_end) begin
              baud_q <= '0;
              if (bit_q == STOP_LAST) begin
                state_q <= S_IDLE;
                bit_q   <= '0;
                sdata_q <= 1'b1;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            sdata_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
